// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core, host-loader and memory-bus signals around the memory port arbiter.
// master: the arbiter; slave: the requesters and the memory seen from the other side.
interface mem_port_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 15
);
   logic          host_lock;

   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_adr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_stall;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;

   logic          host_req;
   logic          host_we;
   logic [AW-1:0] host_adr;
   logic [DW-1:0] host_wdata;
   logic          host_gnt;
   logic          host_rvalid;
   logic [DW-1:0] host_rdata;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport master (
      input  host_lock,
      input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
      output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      input  host_req, host_we, host_adr, host_wdata,
      output host_gnt, host_rvalid, host_rdata,
      output mem_en, mem_we, mem_adr, mem_wdata,
      input  mem_rdata
   );

   modport slave (
      output host_lock,
      output cpu_req, cpu_we, cpu_adr, cpu_wdata,
      input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
      output host_req, host_we, host_adr, host_wdata,
      input  host_gnt, host_rvalid, host_rdata,
      input  mem_en, mem_we, mem_adr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between core and host loader: grant is combinational, bus is registered
// one cycle later, read data returns RD_LAT cycles after that; losers are held off via gnt/stall.
module mem_port_arbiter #(
   parameter int AW     = 8,
   parameter int DW     = 15,
   parameter int RD_LAT = 1
) (
   input  logic               ph1,
   input  logic               reset,
   mem_port_arbiter_if.master bus
);
   logic              w_cpu_gnt;
   logic              w_host_gnt;
   logic              w_any_gnt;
   logic              w_sel_we;
   logic [AW-1:0]     w_sel_adr;
   logic [DW-1:0]     w_sel_wdata;
   logic              w_rd_push;
   logic [RD_LAT:0]   w_vld_shift;
   logic [RD_LAT:0]   w_own_shift;
   logic              w_tail_vld;
   logic              w_tail_host;
   logic              w_cpu_rvalid;
   logic              w_host_rvalid;

   logic              r_last_host;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [AW-1:0]     r_mem_adr;
   logic [DW-1:0]     r_mem_wdata;
   logic [RD_LAT-1:0] r_tag_vld;
   logic [RD_LAT-1:0] r_tag_host;

   // Grants are gated by reset so nothing is accepted while the port is being cleared.
   always_comb begin
      w_cpu_gnt  = 1'b0;
      w_host_gnt = 1'b0;
      if (reset) begin
         if (bus.host_lock) begin
            w_host_gnt = bus.host_req;
            w_cpu_gnt  = bus.cpu_req & ~bus.host_req;
         end else if (bus.cpu_req && bus.host_req) begin
            w_cpu_gnt  = r_last_host;
            w_host_gnt = ~r_last_host;
         end else begin
            w_cpu_gnt  = bus.cpu_req;
            w_host_gnt = bus.host_req;
         end
      end
   end

   assign w_any_gnt   = w_cpu_gnt | w_host_gnt;
   assign w_sel_we    = w_host_gnt ? bus.host_we    : bus.cpu_we;
   assign w_sel_adr   = w_host_gnt ? bus.host_adr   : bus.cpu_adr;
   assign w_sel_wdata = w_host_gnt ? bus.host_wdata : bus.cpu_wdata;

   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         r_last_host <= 1'b1;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_adr   <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_en <= w_any_gnt;
         r_mem_we <= w_any_gnt & w_sel_we;
         if (w_any_gnt) begin
            r_mem_adr   <= w_sel_adr;
            r_mem_wdata <= w_sel_wdata;
            r_last_host <= w_host_gnt;
         end
      end
   end

   // While mem_en is high r_last_host names the owner of the access on the bus.
   assign w_rd_push   = r_mem_en & ~r_mem_we;
   assign w_vld_shift = {r_tag_vld, w_rd_push};
   assign w_own_shift = {r_tag_host, r_last_host};

   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         r_tag_vld  <= '0;
         r_tag_host <= '0;
      end else begin
         r_tag_vld  <= w_vld_shift[RD_LAT-1:0];
         r_tag_host <= w_own_shift[RD_LAT-1:0];
      end
   end

   assign w_tail_vld    = r_tag_vld[RD_LAT-1];
   assign w_tail_host   = r_tag_host[RD_LAT-1];
   assign w_cpu_rvalid  = w_tail_vld & ~w_tail_host;
   assign w_host_rvalid = w_tail_vld & w_tail_host;

   assign bus.cpu_gnt     = w_cpu_gnt;
   assign bus.cpu_stall   = bus.cpu_req & ~w_cpu_gnt;
   assign bus.cpu_rvalid  = w_cpu_rvalid;
   assign bus.cpu_rdata   = w_cpu_rvalid ? bus.mem_rdata : '0;
   assign bus.host_gnt    = w_host_gnt;
   assign bus.host_rvalid = w_host_rvalid;
   assign bus.host_rdata  = w_host_rvalid ? bus.mem_rdata : '0;
   assign bus.mem_en      = r_mem_en;
   assign bus.mem_we      = r_mem_we;
   assign bus.mem_adr     = r_mem_adr;
   assign bus.mem_wdata   = r_mem_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives two arbiters (RD_LAT 1 and 3) with identical requester traffic and checks both
// every cycle against a transaction-level model, plus directed literal expectations.
module tb_mem_port_arbiter;
   logic        ph1 = 1'b0;
   logic        rst;
   logic        host_lock;
   logic        cpu_req, cpu_we, host_req, host_we;
   logic [7:0]  cpu_adr, host_adr;
   logic [14:0] cpu_wdata, host_wdata;

   int vectors = 0;
   int miscompares = 0;

   always #5 ph1 = ~ph1;

   mem_port_arbiter_if #(.AW(8), .DW(15)) ifa ();
   mem_port_arbiter_if #(.AW(8), .DW(15)) ifb ();

   mem_port_arbiter #(.AW(8), .DW(15), .RD_LAT(1)) dut_a (.ph1(ph1), .reset(rst), .bus(ifa));
   mem_port_arbiter #(.AW(8), .DW(15), .RD_LAT(3)) dut_b (.ph1(ph1), .reset(rst), .bus(ifb));

   assign ifa.host_lock = host_lock;   assign ifb.host_lock = host_lock;
   assign ifa.cpu_req   = cpu_req;     assign ifb.cpu_req   = cpu_req;
   assign ifa.cpu_we    = cpu_we;      assign ifb.cpu_we    = cpu_we;
   assign ifa.cpu_adr   = cpu_adr;     assign ifb.cpu_adr   = cpu_adr;
   assign ifa.cpu_wdata = cpu_wdata;   assign ifb.cpu_wdata = cpu_wdata;
   assign ifa.host_req  = host_req;    assign ifb.host_req  = host_req;
   assign ifa.host_we   = host_we;     assign ifb.host_we   = host_we;
   assign ifa.host_adr  = host_adr;    assign ifb.host_adr  = host_adr;
   assign ifa.host_wdata = host_wdata; assign ifb.host_wdata = host_wdata;

   function automatic logic [14:0] minit(input logic [7:0] a);
      logic [14:0] t;
      t = {7'h00, a} << 4;
      return t ^ 15'h1334;
   endfunction

   // Memory behind each arbiter: writes land on the mem_en edge, reads return RD_LAT later.
   logic [14:0] mem_a [256];
   logic [14:0] mem_b [256];
   logic [14:0] pa, pb0, pb1, pb2;
   bit          mem_ok = 1'b0;
   always @(posedge ph1) begin
      if (!mem_ok) begin
         for (int i = 0; i < 256; i++) begin
            mem_a[i] <= minit(8'(i));
            mem_b[i] <= minit(8'(i));
         end
         mem_ok <= 1'b1;
      end else begin
         if (ifa.mem_en && ifa.mem_we) mem_a[ifa.mem_adr] <= ifa.mem_wdata;
         if (ifb.mem_en && ifb.mem_we) mem_b[ifb.mem_adr] <= ifb.mem_wdata;
      end
      pa  <= mem_a[ifa.mem_adr];
      pb0 <= mem_b[ifb.mem_adr];
      pb1 <= pb0;
      pb2 <= pb1;
   end
   assign ifa.mem_rdata = pa;
   assign ifb.mem_rdata = pb2;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic        cpu_gnt;
      logic        host_gnt;
      logic        cpu_stall;
      logic        mem_en;
      logic        mem_we;
      logic [7:0]  mem_adr;
      logic [14:0] mem_wdata;
      logic        cpu_rvalid;
      logic [14:0] cpu_rdata;
      logic        host_rvalid;
      logic [14:0] host_rdata;
   } obs_t;

   obs_t obs_a, obs_b;
   assign obs_a = {ifa.cpu_gnt, ifa.host_gnt, ifa.cpu_stall, ifa.mem_en, ifa.mem_we, ifa.mem_adr,
                   ifa.mem_wdata, ifa.cpu_rvalid, ifa.cpu_rdata, ifa.host_rvalid, ifa.host_rdata};
   assign obs_b = {ifb.cpu_gnt, ifb.host_gnt, ifb.cpu_stall, ifb.mem_en, ifb.mem_we, ifb.mem_adr,
                   ifb.mem_wdata, ifb.cpu_rvalid, ifb.cpu_rdata, ifb.host_rvalid, ifb.host_rdata};

   // Transaction model: who wins, what the bus shows next cycle, and which read is due when.
   typedef struct { bit host; logic [14:0] data; } pend_t;
   pend_t       rd [int];
   logic [14:0] gold [256];
   int          cyc;
   bit          m_last_host, m_en, m_we;
   logic [7:0]  m_adr;
   logic [14:0] m_wd;
   bit          eg_c, eg_h, c_wait, h_wait;
   logic [7:0]  c_adr_q, h_adr_q;
   obs_t        od, e;
   pend_t       p;
   int          lat [2] = '{1, 3};

   initial begin
      for (int i = 0; i < 256; i++) gold[i] = minit(8'(i));
      cyc = 0; m_last_host = 1'b1; m_en = 1'b0; m_we = 1'b0; m_adr = '0; m_wd = '0;
      c_wait = 1'b0; h_wait = 1'b0; c_adr_q = '0; h_adr_q = '0;
      forever begin
         @(negedge ph1);
         if (rst && c_wait)
            assert (cpu_req && cpu_adr == c_adr_q) else $error("cpu request withdrawn before grant");
         if (rst && h_wait)
            assert (host_req && host_adr == h_adr_q) else $error("host request withdrawn before grant");
         eg_c = 1'b0; eg_h = 1'b0;
         if (rst) begin
            if (host_lock) begin
               eg_h = host_req; eg_c = cpu_req && !host_req;
            end else if (cpu_req && host_req) begin
               eg_c = m_last_host; eg_h = !m_last_host;
            end else begin
               eg_c = cpu_req; eg_h = host_req;
            end
         end
         for (int d = 0; d < 2; d++) begin
            string sfx;
            sfx = $sformatf("_lat%0d", lat[d]);
            od = (d == 0) ? obs_a : obs_b;
            e = '0;
            e.cpu_gnt = eg_c; e.host_gnt = eg_h; e.cpu_stall = cpu_req && !eg_c;
            if (rst) begin
               e.mem_en = m_en; e.mem_we = m_we; e.mem_adr = m_adr; e.mem_wdata = m_wd;
               if (rd.exists(cyc - 1 - lat[d])) begin
                  p = rd[cyc - 1 - lat[d]];
                  if (p.host) begin e.host_rvalid = 1'b1; e.host_rdata = p.data; end
                  else begin e.cpu_rvalid = 1'b1; e.cpu_rdata = p.data; end
               end
            end
            chk({"cpu_gnt", sfx},     od.cpu_gnt,     e.cpu_gnt);
            chk({"host_gnt", sfx},    od.host_gnt,    e.host_gnt);
            chk({"cpu_stall", sfx},   od.cpu_stall,   e.cpu_stall);
            chk({"mem_en", sfx},      od.mem_en,      e.mem_en);
            chk({"mem_we", sfx},      od.mem_we,      e.mem_we);
            chk({"mem_adr", sfx},     od.mem_adr,     e.mem_adr);
            chk({"mem_wdata", sfx},   od.mem_wdata,   e.mem_wdata);
            chk({"cpu_rvalid", sfx},  od.cpu_rvalid,  e.cpu_rvalid);
            chk({"cpu_rdata", sfx},   od.cpu_rdata,   e.cpu_rdata);
            chk({"host_rvalid", sfx}, od.host_rvalid, e.host_rvalid);
            chk({"host_rdata", sfx},  od.host_rdata,  e.host_rdata);
         end
         c_wait = rst && cpu_req && !ifa.cpu_gnt;   c_adr_q = cpu_adr;
         h_wait = rst && host_req && !ifa.host_gnt; h_adr_q = host_adr;
         @(posedge ph1);
         if (!rst) begin
            m_last_host = 1'b1; m_en = 1'b0; m_we = 1'b0; m_adr = '0; m_wd = '0;
            rd.delete();
         end else begin
            m_en = eg_c || eg_h;
            m_we = eg_h ? host_we : (eg_c && cpu_we);
            if (eg_c || eg_h) begin
               m_adr = eg_h ? host_adr : cpu_adr;
               m_wd  = eg_h ? host_wdata : cpu_wdata;
               m_last_host = eg_h;
               if (m_we) gold[m_adr] = m_wd;
               else rd[cyc] = '{host: eg_h, data: gold[m_adr]};
            end
         end
         cyc++;
      end
   end

   task automatic tick();
      @(posedge ph1); #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
   endtask

   // Both requesters ask continuously until each has had n grants; records grant/stall per cycle.
   task automatic both_loop(input bit cwe, input bit hwe, input logic [7:0] cbase,
                            input logic [7:0] hbase, input int n,
                            output logic [15:0] gpat, output logic [15:0] spat);
      int kc = 0, kh = 0, t = 0;
      logic [7:0] ca = cbase, ha = hbase;
      bit cg, hg;
      gpat = '0; spat = '0;
      cpu_req = 1'b1;  cpu_we = cwe;  cpu_adr = ca;  cpu_wdata = {7'h11, ca};
      host_req = 1'b1; host_we = hwe; host_adr = ha; host_wdata = {7'h22, ha};
      while ((cpu_req || host_req) && t < 60) begin
         @(negedge ph1);
         cg = ifa.cpu_gnt; hg = ifa.host_gnt;
         if (t < 16) begin gpat[t] = cg; spat[t] = ifa.cpu_stall; end
         tick();
         t++;
         if (cg) begin
            kc++;
            if (kc >= n) cpu_req = 1'b0;
            else begin ca++; cpu_adr = ca; cpu_wdata = {7'h11, ca}; end
         end
         if (hg) begin
            kh++;
            if (kh >= n) host_req = 1'b0;
            else begin ha++; host_adr = ha; host_wdata = {7'h22, ha}; end
         end
      end
      chk("both_loop_done", (t < 60) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      logic [15:0] g, s;
      int hcnt, scnt;
      rst = 1'b0; host_lock = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
      host_req = 1'b0; host_we = 1'b0; host_adr = '0; host_wdata = '0;
      repeat (3) @(posedge ph1);
      #1 rst = 1'b1;

      // single core read of 0x10
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 8'h10;
      @(negedge ph1);
      chk("t1_cpu_gnt", ifa.cpu_gnt, 1); chk("t1_host_gnt", ifa.host_gnt, 0);
      tick(); cpu_req = 1'b0;
      @(negedge ph1);
      chk("t1_mem_en", ifa.mem_en, 1); chk("t1_mem_adr", ifa.mem_adr, 32'h10); chk("t1_mem_we", ifa.mem_we, 0);
      @(negedge ph1);
      chk("t1_rvalid_l1", ifa.cpu_rvalid, 1); chk("t1_rdata_l1", ifa.cpu_rdata, 32'h1234);
      chk("t1_rvalid_l3_early", ifb.cpu_rvalid, 0);
      @(negedge ph1); @(negedge ph1);
      chk("t1_rvalid_l3", ifb.cpu_rvalid, 1); chk("t1_rdata_l3", ifb.cpu_rdata, 32'h1234);
      tick();

      // round robin from reset: core takes the first tie
      do_reset();
      both_loop(1'b0, 1'b0, 8'h20, 8'h30, 4, g, s);
      chk("t2_grant_pattern", g[7:0], 32'h55);
      chk("t2_stall_pattern", s[7:0], 32'h2A);

      // host lock: 8 host writes while the core waits
      host_lock = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 8'h05;
      hcnt = 0; scnt = 0;
      for (int i = 0; i < 8; i++) begin
         host_req = 1'b1; host_we = 1'b1; host_adr = 8'(i); host_wdata = 15'h7000 + 15'(i);
         @(negedge ph1);
         hcnt += int'(ifa.host_gnt); scnt += int'(ifa.cpu_stall);
         tick();
      end
      host_req = 1'b0; host_lock = 1'b0;
      chk("t3_host_grants", hcnt, 8); chk("t3_cpu_stalls", scnt, 8);
      @(negedge ph1);
      chk("t3_cpu_gnt_after_unlock", ifa.cpu_gnt, 1);
      tick(); cpu_req = 1'b0;
      @(negedge ph1); @(negedge ph1);
      chk("t3_rdata", ifa.cpu_rdata, 32'h7005);
      tick();

      // back-to-back reads from alternating owners
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 8'h01;
      @(negedge ph1); chk("t4_gnt0", ifa.cpu_gnt, 1);
      tick(); cpu_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_adr = 8'h02;
      @(negedge ph1); chk("t4_gnt1", ifa.host_gnt, 1);
      tick(); host_req = 1'b0; cpu_req = 1'b1; cpu_adr = 8'h03;
      @(negedge ph1); chk("t4_gnt2", ifa.cpu_gnt, 1);
      tick(); cpu_req = 1'b0;
      @(negedge ph1); @(negedge ph1);
      chk("t4_r0_cpu", ifb.cpu_rvalid, 1); chk("t4_r0_data", ifb.cpu_rdata, 32'h7001);
      chk("t4_r0_host", ifb.host_rvalid, 0);
      @(negedge ph1);
      chk("t4_r1_host", ifb.host_rvalid, 1); chk("t4_r1_data", ifb.host_rdata, 32'h7002);
      chk("t4_r1_cpu", ifb.cpu_rvalid, 0);
      @(negedge ph1);
      chk("t4_r2_cpu", ifb.cpu_rvalid, 1); chk("t4_r2_data", ifb.cpu_rdata, 32'h7003);
      tick();

      // host write then core read of the same word
      host_req = 1'b1; host_we = 1'b1; host_adr = 8'h40; host_wdata = 15'h0ABC;
      @(negedge ph1); chk("t5_host_gnt", ifa.host_gnt, 1);
      tick(); host_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 8'h40;
      @(negedge ph1); chk("t5_mem_we_wr", ifa.mem_we, 1); chk("t5_cpu_gnt", ifa.cpu_gnt, 1);
      tick(); cpu_req = 1'b0;
      @(negedge ph1); chk("t5_mem_we_rd", ifa.mem_we, 0); chk("t5_mem_en_rd", ifa.mem_en, 1);
      @(negedge ph1); chk("t5_rdata", ifa.cpu_rdata, 32'h0ABC); chk("t5_no_host_rvalid", ifa.host_rvalid, 0);
      tick();

      // reset while a read is on the bus
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 8'h10;
      @(negedge ph1); chk("t6_gnt", ifa.cpu_gnt, 1);
      tick(); cpu_req = 1'b0;
      @(negedge ph1); chk("t6_mem_en_pre", ifa.mem_en, 1);
      #1 rst = 1'b0;
      tick(); rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge ph1);
         chk("t6_no_rvalid_l1", ifa.cpu_rvalid, 0); chk("t6_no_rvalid_l3", ifb.cpu_rvalid, 0);
         chk("t6_mem_en", ifa.mem_en, 0);
         tick();
      end
      both_loop(1'b0, 1'b0, 8'h60, 8'h70, 2, g, s);
      chk("t6_cpu_first", g[3:0], 32'h5);

      // mixed traffic, then locked traffic
      both_loop(1'b0, 1'b1, 8'h50, 8'h50, 3, g, s);
      host_lock = 1'b1;
      both_loop(1'b1, 1'b0, 8'h08, 8'h09, 2, g, s);
      chk("t7_lock_pattern", g[3:0], 32'hC);
      host_lock = 1'b0;

      repeat (6) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
